// File: rtl/x_io_pkg.sv
// Shared definitions for the keypad input path: key layout, scan FSM states and entry limits.
package x_io_pkg;

    localparam int MAX_DIGITS = 8;

    typedef enum logic [1:0] {
        IDLE,
        CONFIRM,
        HELD,
        RELEASE
    } key_state_e;

    typedef enum logic [1:0] {
        FR_NONE,
        FR_SINGLE,
        FR_MULTI
    } frame_res_e;

    // KEYMAP[row][col]; * maps to E and # maps to F.
    localparam logic [3:0] KEYMAP [4][4] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'hE, 4'h0, 4'hF, 4'hD}
    };

endpackage

// File: rtl/x_button_debounce.sv
// Synchronises a raw push button, debounces it and emits a one-cycle pulse on an accepted press.
module x_button_debounce #(
    parameter int BTN_DEB = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic pulse
);

    localparam int CW = $clog2(BTN_DEB + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(BTN_DEB - 1);

    logic          s1_q, s2_q;
    logic          level_q, level_d;
    logic          pulse_q, pulse_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= raw;
            s2_q <= s1_q;
        end
    end

    // The counter only runs while the synchronised level disagrees with the accepted one.
    always_comb begin
        level_d = level_q;
        pulse_d = 1'b0;
        cnt_d   = cnt_q;
        if (s2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            level_d = s2_q;
            pulse_d = s2_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level_q <= 1'b0;
            pulse_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            level_q <= level_d;
            pulse_q <= pulse_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/x_input_keypad.sv
// 4x4 matrix keypad scanner with frame debouncing, hex entry register and a valid/ack
// read port for the committed word.
module x_input_keypad
    import x_io_pkg::*;
#(
    parameter int SCAN_DIV   = 100000,
    parameter int DEB_FRAMES = 4,
    parameter int BTN_DEB    = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  kb_col,
    output logic [3:0]  kb_row,
    input  logic        btn_enter,
    input  logic        btn_back,
    input  logic        ack,
    output logic [31:0] value,
    output logic [3:0]  digit_cnt,
    output logic [31:0] data,
    output logic        data_valid,
    output logic        key_valid,
    output logic [3:0]  key_code
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int FW = $clog2(DEB_FRAMES + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [FW-1:0] FRAMES   = FW'(DEB_FRAMES);

    logic [3:0]    col_s1_q, col_s2_q;
    logic [DW-1:0] div_q, div_d;
    logic [1:0]    row_q, row_d;
    logic [1:0]    hit_cnt_q, hit_cnt_d;
    logic [3:0]    hit_code_q, hit_code_d;
    key_state_e    state_q, state_d;
    logic [3:0]    cand_q, cand_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          key_valid_q, key_valid_d;
    logic [3:0]    key_code_q, key_code_d;
    logic [31:0]   value_q, value_d;
    logic [3:0]    digit_cnt_q, digit_cnt_d;
    logic [31:0]   data_q, data_d;
    logic          data_valid_q, data_valid_d;

    logic          enter_p, back_p;
    logic          row_end, frame_end;
    logic [2:0]    row_hits, tot_hits;
    logic [3:0]    row_code, frame_code;
    frame_res_e    fres;

    x_button_debounce #(.BTN_DEB(BTN_DEB)) u_enter (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_enter),
        .pulse (enter_p)
    );

    x_button_debounce #(.BTN_DEB(BTN_DEB)) u_back (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_back),
        .pulse (back_p)
    );

    // Columns idle high through the pull-ups, so the synchroniser resets to "no key".
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_s1_q <= 4'hF;
            col_s2_q <= 4'hF;
        end else begin
            col_s1_q <= kb_col;
            col_s2_q <= col_s1_q;
        end
    end

    always_comb begin
        row_end   = (div_q == DIV_LAST);
        frame_end = row_end && (row_q == 2'd3);
        div_d     = row_end ? '0 : div_q + DW'(1);
        row_d     = row_end ? row_q + 2'd1 : row_q;

        row_hits = '0;
        row_code = '0;
        for (int c = 0; c < 4; c++) begin
            if (!col_s2_q[c[1:0]]) begin
                row_hits = row_hits + 3'd1;
                row_code = KEYMAP[row_q][c[1:0]];
            end
        end
        tot_hits   = {1'b0, hit_cnt_q} + row_hits;
        frame_code = (row_hits != 3'd0) ? row_code : hit_code_q;

        if (tot_hits == 3'd0)      fres = FR_NONE;
        else if (tot_hits == 3'd1) fres = FR_SINGLE;
        else                       fres = FR_MULTI;

        // Hit count saturates at 2: anything beyond that is simply MULTI.
        hit_cnt_d  = hit_cnt_q;
        hit_code_d = hit_code_q;
        if (frame_end) begin
            hit_cnt_d  = '0;
            hit_code_d = '0;
        end else if (row_end) begin
            hit_cnt_d  = (tot_hits > 3'd2) ? 2'd2 : tot_hits[1:0];
            hit_code_d = frame_code;
        end
    end

    always_comb begin
        state_d     = state_q;
        cand_d      = cand_q;
        fcnt_d      = fcnt_q;
        key_valid_d = 1'b0;
        key_code_d  = key_code_q;
        if (frame_end) begin
            case (state_q)
                IDLE: begin
                    if (fres == FR_SINGLE) begin
                        if (DEB_FRAMES <= 1) begin
                            state_d     = HELD;
                            key_valid_d = 1'b1;
                            key_code_d  = frame_code;
                            fcnt_d      = '0;
                        end else begin
                            state_d = CONFIRM;
                            cand_d  = frame_code;
                            fcnt_d  = FW'(1);
                        end
                    end
                end
                CONFIRM: begin
                    if (fres == FR_SINGLE && frame_code == cand_q) begin
                        if (fcnt_q + FW'(1) >= FRAMES) begin
                            state_d     = HELD;
                            key_valid_d = 1'b1;
                            key_code_d  = cand_q;
                            fcnt_d      = '0;
                        end else begin
                            fcnt_d = fcnt_q + FW'(1);
                        end
                    end else if (fres == FR_SINGLE) begin
                        cand_d = frame_code;
                        fcnt_d = FW'(1);
                    end else begin
                        state_d = IDLE;
                        fcnt_d  = '0;
                    end
                end
                HELD: begin
                    if (fres == FR_NONE) begin
                        if (DEB_FRAMES <= 1) begin
                            state_d = IDLE;
                            fcnt_d  = '0;
                        end else begin
                            state_d = RELEASE;
                            fcnt_d  = FW'(1);
                        end
                    end
                end
                RELEASE: begin
                    if (fres != FR_NONE) begin
                        state_d = HELD;
                        fcnt_d  = '0;
                    end else if (fcnt_q + FW'(1) >= FRAMES) begin
                        state_d = IDLE;
                        fcnt_d  = '0;
                    end else begin
                        fcnt_d = fcnt_q + FW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    fcnt_d  = '0;
                end
            endcase
        end
    end

    // ENTER wins over BACKSPACE, which wins over a key; ack only loses against ENTER.
    always_comb begin
        value_d      = value_q;
        digit_cnt_d  = digit_cnt_q;
        data_d       = data_q;
        data_valid_d = data_valid_q;
        if (enter_p) begin
            data_d       = value_q;
            data_valid_d = 1'b1;
            value_d      = '0;
            digit_cnt_d  = '0;
        end else begin
            if (ack) data_valid_d = 1'b0;
            if (back_p) begin
                if (digit_cnt_q != 4'd0) begin
                    value_d     = {4'h0, value_q[31:4]};
                    digit_cnt_d = digit_cnt_q - 4'd1;
                end
            end else if (key_valid_q && digit_cnt_q < 4'(MAX_DIGITS)) begin
                value_d     = {value_q[27:0], key_code_q};
                digit_cnt_d = digit_cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q        <= '0;
            row_q        <= '0;
            hit_cnt_q    <= '0;
            hit_code_q   <= '0;
            state_q      <= IDLE;
            cand_q       <= '0;
            fcnt_q       <= '0;
            key_valid_q  <= 1'b0;
            key_code_q   <= '0;
            value_q      <= '0;
            digit_cnt_q  <= '0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
        end else begin
            div_q        <= div_d;
            row_q        <= row_d;
            hit_cnt_q    <= hit_cnt_d;
            hit_code_q   <= hit_code_d;
            state_q      <= state_d;
            cand_q       <= cand_d;
            fcnt_q       <= fcnt_d;
            key_valid_q  <= key_valid_d;
            key_code_q   <= key_code_d;
            value_q      <= value_d;
            digit_cnt_q  <= digit_cnt_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
        end
    end

    assign kb_row     = ~(4'b0001 << row_q);
    assign value      = value_q;
    assign digit_cnt  = digit_cnt_q;
    assign data       = data_q;
    assign data_valid = data_valid_q;
    assign key_valid  = key_valid_q;
    assign key_code   = key_code_q;

endmodule
